// File: rtl/cpu_step_controller_pkg.sv
// cpu_step_controller_pkg: opcodes, FSM states and datapath select/trap codes for the RV32I step controller
package cpu_step_controller_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [1:0] PC_SEL_SEQ   = 2'b00;
  localparam logic [1:0] PC_SEL_REL   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;
  localparam logic [1:0] WB_SEL_ALU   = 2'b00;
  localparam logic [1:0] WB_SEL_MEM   = 2'b01;
  localparam logic [1:0] WB_SEL_PC4   = 2'b10;
  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic uses_wb;
    logic legal;
  } iclass_t;
endpackage

// File: rtl/cpu_step_controller_decode.sv
// instr_class_decode: combinational opcode classification for the step controller
module instr_class_decode
  import cpu_step_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls
);
  logic alu_like;
  assign alu_like      = opcode == OPC_OP_IMM || opcode == OPC_OP || opcode == OPC_LUI || opcode == OPC_AUIPC;
  assign cls.is_load   = opcode == OPC_LOAD;
  assign cls.is_store  = opcode == OPC_STORE;
  assign cls.is_branch = opcode == OPC_BRANCH;
  assign cls.is_jal    = opcode == OPC_JAL;
  assign cls.is_jalr   = opcode == OPC_JALR;
  assign cls.uses_wb   = alu_like || cls.is_load || cls.is_jal || cls.is_jalr;
  assign cls.legal     = cls.uses_wb || cls.is_store || cls.is_branch;
endmodule

// File: rtl/cpu_step_controller.sv
// cpu_step_controller: multi-cycle RV32I sequencer driving datapath enables, with mem timeout,
// illegal-opcode trap and retired-instruction counter
module cpu_step_controller
  import cpu_step_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [RET_W-1:0] instr_retired
);
  localparam int WW = $clog2(MEM_TIMEOUT + 2);
  state_t        state, state_d, boundary;
  iclass_t       cls;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    cause_d;
  logic          timed_out;
  instr_class_decode u_decode (.opcode(opcode), .cls(cls));
  // timed_out marks the MEM_TIMEOUT-th consecutive cycle without mem_ready
  assign timed_out = MEM_TIMEOUT != 0 && wait_cnt == WW'(MEM_TIMEOUT - 1);
  assign boundary  = run ? S_FETCH : S_IDLE;
  assign busy      = state != S_IDLE && state != S_TRAP;
  assign trap      = trap_cause != TRAP_NONE;
  always_comb begin
    state_d  = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = WB_SEL_ALU;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    cause_d  = TRAP_NONE;
    case (state)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        state_d = mem_ready ? S_DECODE : timed_out ? S_TRAP : S_FETCH;
        cause_d = !mem_ready && timed_out ? TRAP_TIMEOUT : TRAP_NONE;
      end
      S_DECODE: begin
        state_d = cls.legal ? S_EXECUTE : S_TRAP;
        cause_d = cls.legal ? TRAP_NONE : TRAP_ILLEGAL;
      end
      S_EXECUTE: begin
        pc_we   = cls.is_branch;
        pc_sel  = cls.is_branch && branch_taken ? PC_SEL_REL : PC_SEL_SEQ;
        state_d = cls.is_branch ? boundary : (cls.is_load || cls.is_store) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = cls.is_store;
        pc_we    = mem_ready && cls.is_store;
        state_d  = mem_ready ? (cls.is_store ? boundary : S_WRITEBACK) : timed_out ? S_TRAP : S_MEM;
        cause_d  = !mem_ready && timed_out ? TRAP_TIMEOUT : TRAP_NONE;
      end
      S_WRITEBACK: begin
        rf_we   = cls.uses_wb;
        pc_we   = 1'b1;
        wb_sel  = cls.is_load ? WB_SEL_MEM : (cls.is_jal || cls.is_jalr) ? WB_SEL_PC4 : WB_SEL_ALU;
        pc_sel  = cls.is_jal ? PC_SEL_REL : cls.is_jalr ? PC_SEL_JALR : PC_SEL_SEQ;
        state_d = boundary;
      end
      default: state_d = state;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      trap_cause    <= TRAP_NONE;
      instr_retired <= '0;
    end else begin
      state         <= state_d;
      wait_cnt      <= state_d == state && (state == S_FETCH || state == S_MEM) ? wait_cnt + 1'b1 : '0;
      if (cause_d != TRAP_NONE) trap_cause <= cause_d;
      if (pc_we) instr_retired <= instr_retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_step_controller.sv
// tb_cpu_step_controller: directed per-cycle vectors with hand-computed control patterns
module tb_cpu_step_controller;
  import cpu_step_controller_pkg::*;
  // {mem_req, mem_we, addr_sel, ir_we, rf_we, wb_sel, pc_we, pc_sel, busy, trap, trap_cause}
  localparam logic [13:0] IDL     = 14'b0_0_0_0_0_00_0_00_0_0_00;
  localparam logic [13:0] FET_R   = 14'b1_0_0_1_0_00_0_00_1_0_00;
  localparam logic [13:0] FET_W   = 14'b1_0_0_0_0_00_0_00_1_0_00;
  localparam logic [13:0] DEC     = 14'b0_0_0_0_0_00_0_00_1_0_00;
  localparam logic [13:0] WB_ALU  = 14'b0_0_0_0_1_00_1_00_1_0_00;
  localparam logic [13:0] WB_LD   = 14'b0_0_0_0_1_01_1_00_1_0_00;
  localparam logic [13:0] WB_JAL  = 14'b0_0_0_0_1_10_1_01_1_0_00;
  localparam logic [13:0] WB_JALR = 14'b0_0_0_0_1_10_1_10_1_0_00;
  localparam logic [13:0] MEM_LD  = 14'b1_0_1_0_0_00_0_00_1_0_00;
  localparam logic [13:0] MEM_ST  = 14'b1_1_1_0_0_00_1_00_1_0_00;
  localparam logic [13:0] BR_T    = 14'b0_0_0_0_0_00_1_01_1_0_00;
  localparam logic [13:0] BR_N    = 14'b0_0_0_0_0_00_1_00_1_0_00;
  localparam logic [13:0] TRP_TO  = 14'b0_0_0_0_0_00_0_00_0_1_10;
  localparam logic [13:0] TRP_ILL = 14'b0_0_0_0_0_00_0_00_0_1_01;
  logic clk = 0, reset = 0, run = 0, branch_taken = 0, mem_ready = 0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we, busy, trap;
  logic [1:0] wb_sel, pc_sel, trap_cause;
  logic [31:0] instr_retired;
  logic [13:0] ctl;
  int n_chk = 0, n_pass = 0;
  cpu_step_controller #(.MEM_TIMEOUT(4), .RET_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .busy(busy), .trap(trap), .trap_cause(trap_cause), .instr_retired(instr_retired)
  );
  assign ctl = {mem_req, mem_we, addr_sel, ir_we, rf_we, wb_sel, pc_we, pc_sel, busy, trap, trap_cause};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc(input string tag, input logic [6:0] o, input logic rn, input logic r,
                     input logic b, input logic [13:0] e);
    opcode = o; run = rn; mem_ready = r; branch_taken = b;
    #1;
    chk(tag, 32'(ctl), 32'(e));
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 0;
    #1;
    chk("async_rst_ctl", 32'(ctl), 32'(IDL));
    @(posedge clk); #1;
    reset = 1;
  endtask
  initial begin
    logic [6:0] alu_ops [3];
    alu_ops = '{OPC_LUI, OPC_AUIPC, OPC_OP};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'(ctl), 32'(IDL));
    chk("rst_ret", instr_retired, 0);
    reset = 1;
    cyc("idle0", OPC_OP_IMM, 0, 1, 0, IDL);
    cyc("idle1", OPC_OP_IMM, 0, 1, 0, IDL);
    cyc("addi_idle", OPC_OP_IMM, 1, 1, 0, IDL);
    cyc("addi_f", OPC_OP_IMM, 1, 1, 0, FET_R);
    cyc("addi_d", OPC_OP_IMM, 1, 1, 0, DEC);
    cyc("addi_e", OPC_OP_IMM, 1, 1, 0, DEC);
    cyc("addi_wb", OPC_OP_IMM, 1, 1, 0, WB_ALU);
    chk("ret_addi", instr_retired, 1);
    cyc("jal_f", OPC_JAL, 1, 1, 0, FET_R);
    cyc("jal_d", OPC_JAL, 1, 1, 0, DEC);
    cyc("jal_e", OPC_JAL, 1, 1, 0, DEC);
    cyc("jal_wb", OPC_JAL, 1, 1, 0, WB_JAL);
    cyc("jalr_f", OPC_JALR, 1, 1, 0, FET_R);
    cyc("jalr_d", OPC_JALR, 1, 1, 0, DEC);
    cyc("jalr_e", OPC_JALR, 1, 1, 0, DEC);
    cyc("jalr_wb", OPC_JALR, 1, 1, 0, WB_JALR);
    chk("ret_jumps", instr_retired, 3);
    foreach (alu_ops[i]) begin
      cyc("alu_f", alu_ops[i], 1, 1, 0, FET_R);
      cyc("alu_d", alu_ops[i], 1, 1, 0, DEC);
      cyc("alu_e", alu_ops[i], 1, 1, 0, DEC);
      cyc("alu_wb", alu_ops[i], 1, 1, 0, WB_ALU);
    end
    chk("ret_alu", instr_retired, 6);
    cyc("brt_f", OPC_BRANCH, 1, 1, 1, FET_R);
    cyc("brt_d", OPC_BRANCH, 1, 1, 1, DEC);
    cyc("brt_e", OPC_BRANCH, 1, 1, 1, BR_T);
    cyc("brn_f", OPC_BRANCH, 1, 1, 0, FET_R);
    cyc("brn_d", OPC_BRANCH, 1, 1, 0, DEC);
    cyc("brn_e", OPC_BRANCH, 1, 1, 0, BR_N);
    chk("ret_branch", instr_retired, 8);
    cyc("st_f", OPC_STORE, 1, 1, 0, FET_R);
    cyc("st_d", OPC_STORE, 1, 1, 0, DEC);
    cyc("st_e", OPC_STORE, 1, 1, 0, DEC);
    cyc("st_m", OPC_STORE, 1, 1, 0, MEM_ST);
    chk("ret_store", instr_retired, 9);
    cyc("ldw_f", OPC_LOAD, 1, 1, 0, FET_R);
    cyc("ldw_d", OPC_LOAD, 1, 0, 0, DEC);
    cyc("ldw_e", OPC_LOAD, 1, 0, 0, DEC);
    for (int i = 0; i < 3; i++) cyc("ldw_mwait", OPC_LOAD, 1, 0, 0, MEM_LD);
    cyc("ldw_mrdy", OPC_LOAD, 1, 1, 0, MEM_LD);
    cyc("ldw_wb", OPC_LOAD, 1, 1, 0, WB_LD);
    chk("ret_load", instr_retired, 10);
    cyc("ldr_f", OPC_LOAD, 1, 1, 0, FET_R);
    cyc("ldr_d", OPC_LOAD, 0, 1, 0, DEC);
    cyc("ldr_e", OPC_LOAD, 0, 1, 0, DEC);
    cyc("ldr_m", OPC_LOAD, 0, 1, 0, MEM_LD);
    cyc("ldr_wb", OPC_LOAD, 0, 1, 0, WB_LD);
    cyc("ldr_idle0", OPC_LOAD, 0, 1, 0, IDL);
    cyc("ldr_idle1", OPC_LOAD, 0, 1, 0, IDL);
    chk("ret_rundrop", instr_retired, 11);
    cyc("ab_idle", OPC_OP_IMM, 1, 1, 0, IDL);
    cyc("ab_f", OPC_OP_IMM, 1, 1, 0, FET_R);
    cyc("ab_d", OPC_OP_IMM, 0, 1, 0, DEC);
    #1;
    chk("ab_e", 32'(ctl), 32'(DEC));
    do_reset();
    chk("ab_ret", instr_retired, 0);
    cyc("ab_post", OPC_OP_IMM, 0, 1, 0, IDL);
    cyc("fto_idle", OPC_OP_IMM, 1, 0, 0, IDL);
    for (int i = 0; i < 4; i++) cyc("fto_wait", OPC_OP_IMM, 1, 0, 0, FET_W);
    cyc("fto_trap", OPC_OP_IMM, 1, 1, 0, TRP_TO);
    cyc("fto_hold", 7'b0000000, 1, 1, 1, TRP_TO);
    chk("fto_ret", instr_retired, 0);
    do_reset();
    cyc("mto_idle", OPC_LOAD, 1, 1, 0, IDL);
    cyc("mto_f", OPC_LOAD, 1, 1, 0, FET_R);
    cyc("mto_d", OPC_LOAD, 1, 0, 0, DEC);
    cyc("mto_e", OPC_LOAD, 1, 0, 0, DEC);
    for (int i = 0; i < 4; i++) cyc("mto_wait", OPC_LOAD, 1, 0, 0, MEM_LD);
    cyc("mto_trap", OPC_LOAD, 1, 1, 0, TRP_TO);
    do_reset();
    cyc("ill_idle", 7'b0000000, 1, 1, 0, IDL);
    cyc("ill_f", 7'b0000000, 1, 1, 0, FET_R);
    cyc("ill_d", 7'b0000000, 1, 1, 0, DEC);
    cyc("ill_trap", 7'b0000000, 1, 1, 0, TRP_ILL);
    cyc("ill_hold", OPC_LOAD, 1, 0, 0, TRP_ILL);
    chk("ill_ret", instr_retired, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
